// File: rtl/vector_store_serializer.sv
// Drains one 6-lane vector into single-element memory writes, lowest enabled lane first.
// Holds Busy while draining and pulses Done for one cycle after the final write.
module vector_store_serializer #(
    parameter int N = 8,
    parameter int A = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                StartE,
    input  logic [5:0][N-1:0]   VecDataE,
    input  logic [A-1:0]        BaseAddrE,
    input  logic [3:0]          StrideE,
    input  logic [5:0]          LaneMaskE,
    input  logic                MemReady,
    output logic                MemWE,
    output logic [A-1:0]        MemAddr,
    output logic [N-1:0]        MemWD,
    output logic                Busy,
    output logic                Done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [5:0][N-1:0]  data_q, data_d;
    logic [A-1:0]       base_q, base_d;
    logic [3:0]         stride_q, stride_d;
    logic [5:0]         mask_q, mask_d;

    logic [2:0]         curLane;
    logic [5:0]         curBit;
    logic [6:0]         laneOffset;
    logic               accept;
    logic               handshake;
    logic [5:0]         maskAfterWrite;

    // Lowest remaining lane is the one being written; curBit isolates it for clearing.
    always_comb begin
        curLane = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (mask_q[i]) begin
                curLane = 3'(i);
            end
        end
        curBit = mask_q & (~mask_q + 6'd1);
    end

    assign laneOffset     = {4'b0000, curLane} * {3'b000, stride_q};
    assign accept         = (state_q == IDLE) && StartE;
    assign handshake      = (state_q == WRITE) && MemReady;
    assign maskAfterWrite = mask_q & ~curBit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            data_q   <= '0;
            base_q   <= '0;
            stride_q <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            data_q   <= data_d;
            base_q   <= base_d;
            stride_q <= stride_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (StartE) begin
                    state_d = (LaneMaskE != 6'd0) ? WRITE : DONE;
                end
            end
            WRITE: begin
                if (MemReady && (maskAfterWrite == 6'd0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operands are captured only on the accept cycle, so later input changes are invisible.
    always_comb begin
        data_d   = data_q;
        base_d   = base_q;
        stride_d = stride_q;
        mask_d   = mask_q;
        if (accept) begin
            data_d   = VecDataE;
            base_d   = BaseAddrE;
            stride_d = StrideE;
            mask_d   = LaneMaskE;
        end else if (handshake) begin
            mask_d   = maskAfterWrite;
        end
    end

    always_comb begin
        MemWE   = 1'b0;
        MemAddr = '0;
        MemWD   = '0;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state_q)
            WRITE: begin
                MemWE   = 1'b1;
                MemWD   = data_q[curLane];
                MemAddr = base_q + A'(laneOffset);
                Busy    = 1'b1;
            end
            DONE: begin
                Busy    = 1'b1;
                Done    = 1'b1;
            end
            default: begin
                MemWE   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_vector_store_serializer.sv
// Directed and randomized stores checked cycle by cycle against a lane-list reference model.
module tb_vector_store_serializer;

    localparam int N = 8;
    localparam int A = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               StartE;
    logic [5:0][N-1:0]  VecDataE;
    logic [A-1:0]       BaseAddrE;
    logic [3:0]         StrideE;
    logic [5:0]         LaneMaskE;
    logic               MemReady;
    logic               MemWE;
    logic [A-1:0]       MemAddr;
    logic [N-1:0]       MemWD;
    logic               Busy;
    logic               Done;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    vector_store_serializer #(.N(N), .A(A)) dut (
        .clk       (clk),
        .reset     (reset),
        .StartE    (StartE),
        .VecDataE  (VecDataE),
        .BaseAddrE (BaseAddrE),
        .StrideE   (StrideE),
        .LaneMaskE (LaneMaskE),
        .MemReady  (MemReady),
        .MemWE     (MemWE),
        .MemAddr   (MemAddr),
        .MemWD     (MemWD),
        .Busy      (Busy),
        .Done      (Done)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".MemWE"},   64'(MemWE),   64'd0);
        checkOutput({tag, ".MemAddr"}, 64'(MemAddr), 64'd0);
        checkOutput({tag, ".MemWD"},   64'(MemWD),   64'd0);
        checkOutput({tag, ".Busy"},    64'(Busy),    64'd0);
        checkOutput({tag, ".Done"},    64'(Done),    64'd0);
    endtask

    task automatic scrambleInputs();
        VecDataE  = {$urandom, $urandom};
        BaseAddrE = $urandom;
        StrideE   = 4'($urandom_range(0, 15));
        LaneMaskE = 6'($urandom_range(0, 63));
    endtask

    // Called at #1 after an edge with the DUT in IDLE; leaves the DUT in IDLE the same way.
    task automatic applyStimulus(input string name, input logic [5:0][N-1:0] data, input logic [A-1:0] base,
                                 input logic [3:0] stride, input logic [5:0] mask, input int stallLane,
                                 input int stallCycles, input bit randReady, input bit noisy, input int resetAtWrite);
        logic [A-1:0] expAddr[$];
        logic [N-1:0] expData[$];
        int           idx;
        int           stallsLeft;
        int           streak;
        bit           ready;

        for (int i = 0; i < 6; i++) begin
            if (mask[i]) begin
                expAddr.push_back(base + A'(i * int'(stride)));
                expData.push_back(data[i]);
            end
        end

        StartE    = 1'b1;
        VecDataE  = data;
        BaseAddrE = base;
        StrideE   = stride;
        LaneMaskE = mask;
        MemReady  = 1'b1;
        @(posedge clk); #1;
        StartE = 1'b0;
        scrambleInputs();

        idx        = 0;
        stallsLeft = stallCycles;
        streak     = 0;
        while (idx < expAddr.size()) begin
            checkOutput($sformatf("%s.w%0d.MemWE", name, idx),   64'(MemWE),   64'd1);
            checkOutput($sformatf("%s.w%0d.MemAddr", name, idx), 64'(MemAddr), 64'(expAddr[idx]));
            checkOutput($sformatf("%s.w%0d.MemWD", name, idx),   64'(MemWD),   64'(expData[idx]));
            checkOutput($sformatf("%s.w%0d.Busy", name, idx),    64'(Busy),    64'd1);
            checkOutput($sformatf("%s.w%0d.Done", name, idx),    64'(Done),    64'd0);

            if (resetAtWrite == idx) begin
                reset    = 1'b1;
                StartE   = 1'b0;
                MemReady = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                checkIdle({name, ".postReset"});
                @(posedge clk); #1;
                checkIdle({name, ".postResetHold"});
                return;
            end

            if (idx == stallLane && stallsLeft > 0) begin
                ready = 1'b0;
                stallsLeft--;
            end else if (randReady && streak < 4) begin
                ready = ($urandom_range(0, 3) != 0);
            end else begin
                ready = 1'b1;
            end
            streak   = ready ? 0 : streak + 1;
            MemReady = ready;
            if (noisy) begin
                StartE = 1'($urandom_range(0, 1));
                scrambleInputs();
            end
            @(posedge clk); #1;
            if (ready) idx++;
        end

        StartE   = 1'b0;
        MemReady = 1'($urandom_range(0, 1));
        checkOutput({name, ".done.Done"},    64'(Done),    64'd1);
        checkOutput({name, ".done.Busy"},    64'(Busy),    64'd1);
        checkOutput({name, ".done.MemWE"},   64'(MemWE),   64'd0);
        checkOutput({name, ".done.MemAddr"}, 64'(MemAddr), 64'd0);
        checkOutput({name, ".done.MemWD"},   64'(MemWD),   64'd0);
        @(posedge clk); #1;
        checkIdle({name, ".idle"});
    endtask

    initial begin
        reset     = 1'b1;
        StartE    = 1'b0;
        VecDataE  = '0;
        BaseAddrE = '0;
        StrideE   = '0;
        LaneMaskE = '0;
        MemReady  = 1'b0;
        @(posedge clk); #1;
        checkIdle("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checkIdle("afterReset");

        applyStimulus("full", 48'h66_55_44_33_22_11, 32'h100, 4'd1, 6'b111111, -1, 0, 1'b0, 1'b0, -1);
        applyStimulus("sparse", 48'hA6_A5_A4_A3_A2_A1, 32'h20, 4'd4, 6'b100101, -1, 0, 1'b0, 1'b0, -1);
        applyStimulus("backpressure", 48'h66_55_44_33_22_11, 32'h100, 4'd1, 6'b111111, 2, 3, 1'b0, 1'b0, -1);
        applyStimulus("mask0", 48'hDE_AD_BE_EF_12_34, 32'h40, 4'd2, 6'b000000, -1, 0, 1'b0, 1'b0, -1);
        applyStimulus("wrap", 48'h0F_0E_0D_0C_0B_0A, 32'hFFFF_FFFE, 4'd1, 6'b001111, -1, 0, 1'b0, 1'b0, -1);
        applyStimulus("stride0", 48'hF6_F5_F4_F3_F2_F1, 32'h80, 4'd0, 6'b110000, -1, 0, 1'b0, 1'b1, -1);
        applyStimulus("maxStride", 48'h96_95_94_93_92_91, 32'h1000, 4'd15, 6'b101010, -1, 0, 1'b0, 1'b1, -1);
        applyStimulus("resetMid", 48'h66_55_44_33_22_11, 32'h200, 4'd1, 6'b111111, -1, 0, 1'b0, 1'b0, 3);
        applyStimulus("afterAbort", 48'h77_66_55_44_33_22, 32'h300, 4'd2, 6'b011011, -1, 0, 1'b0, 1'b0, -1);

        for (int t = 0; t < 40; t++) begin
            applyStimulus($sformatf("rand%0d", t), {$urandom, $urandom}, $urandom, 4'($urandom_range(0, 15)),
                          6'($urandom_range(0, 63)), -1, 0, 1'b1, 1'b1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
